// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg
//   Shared types and helpers for the FIFO packet stream reader.
//   state_t     : reader FSM state encoding
//   cnt_width() : width of the in-packet word counter for a given packet length
package fifo_stream_reader_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // At least one bit so PKT_LEN=1 still has a (constant-zero) counter.
  function automatic int cnt_width(input int pkt_len);
    int w;
    w = $clog2(pkt_len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side engine for a showahead single-clock FIFO. Waits until a whole
//   packet of PKT_LEN words is stored, then pops it and presents the words as
//   a framed valid/ready stream (sop/eop) through a registered output stage.
//
//   Optional build macro: FIFO_STREAM_READER_STATS_EN adds pkt_cnt_o, a
//   16-bit wrapping count of accepted end-of-packet words.
//
// Ports
//   clk_i         clock
//   arst_i        asynchronous active-high reset
//   enable_i      permits starting new packets (checked only in IDLE)
//   fifo_q_i      FIFO head word (showahead)
//   fifo_empty_i  FIFO empty
//   fifo_full_i   FIFO full (usedw reads 0 when full)
//   fifo_usedw_i  FIFO fill level
//   fifo_rdreq_o  pop request to the FIFO
//   data_o        stream data
//   valid_o       stream valid
//   ready_i       downstream ready
//   sop_o         first word of packet
//   eop_o         last word of packet
//   busy_o        packet in progress
//   pkt_cnt_o     accepted packet count (STATS build only)
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for enable_i and a complete packet stored in the FIFO
// STREAM | popping the PKT_LEN words of the current packet
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DWIDTH  = 16,
  parameter int AWIDTH  = 8,
  parameter int PKT_LEN = 4
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              enable_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic              fifo_full_i,
  input  logic [AWIDTH-1:0] fifo_usedw_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sop_o,
  output logic              eop_o,
  output logic              busy_o
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [15:0]       pkt_cnt_o
`endif
);

  localparam int CW = cnt_width(PKT_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(PKT_LEN - 1);
  // One extra bit so PKT_LEN = 2**AWIDTH is representable in the compare.
  localparam logic [AWIDTH:0] PKT_LEN_W = (AWIDTH + 1)'(PKT_LEN);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          avail;

  // usedw wraps to 0 at full, so full alone also means a packet is stored.
  assign avail = fifo_full_i | ({1'b0, fifo_usedw_i} >= PKT_LEN_W);

  // Combinational from ready_i so the output register refills in the same
  // cycle it is drained: one word per clock with no bubble.
  assign fifo_rdreq_o = (state == STREAM) & ~fifo_empty_i & (~valid_o | ready_i);

  assign busy_o = (state == STREAM);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      sop_o   <= 1'b0;
      eop_o   <= 1'b0;
    end else begin
      if (fifo_rdreq_o) begin
        data_o  <= fifo_q_i;
        valid_o <= 1'b1;
        sop_o   <= (cnt == '0);
        eop_o   <= (cnt == CNT_LAST);
        cnt     <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      end else if (ready_i) begin
        valid_o <= 1'b0;
        sop_o   <= 1'b0;
        eop_o   <= 1'b0;
      end
      // Without a pop and with ready_i low, data/sop/eop simply hold.

      case (state)
        IDLE: begin
          if (enable_i && avail) begin
            state <= STREAM;
            cnt   <= '0;
          end
        end
        STREAM: begin
          if (fifo_rdreq_o && (cnt == CNT_LAST)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pkt_cnt_o <= '0;
    end else if (valid_o && ready_i && eop_o) begin
      pkt_cnt_o <= pkt_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//   Self-checking bench for fifo_stream_reader. Two instances: PKT_LEN=4 (u0)
//   and PKT_LEN=1 (u1), each fed by a behavioural showahead FIFO. Words are
//   pushed to an expected queue when written; a negedge monitor pops and
//   compares on every accepted beat. Build with FIFO_STREAM_READER_STATS_EN
//   to also check pkt_cnt_o.
module tb_fifo_stream_reader;

  logic clk, arst, frst;
  logic ovr, ovr_full;
  logic [7:0] ovr_usedw;
  logic en [2];
  logic rdy [2];

  logic [15:0] data [2];
  logic valid [2], sop [2], eop [2], busy [2], rdreq [2];
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [15:0] pkt_cnt [2];
`endif

  // behavioural FIFO models
  logic [15:0] mem [2][256];
  logic [7:0]  wp [2], rp [2];
  logic [8:0]  fc [2];
  logic        wr_en [2];
  logic [15:0] wr_data [2];
  logic        wr_ok [2], rd_ok [2];
  logic [15:0] fq [2];
  logic        fe [2], ff [2];
  logic [7:0]  fu [2];

  assign fq[0] = mem[0][rp[0]];
  assign fq[1] = mem[1][rp[1]];
  assign fe[0] = ovr ? 1'b0 : (fc[0] == 9'd0);
  assign fe[1] = (fc[1] == 9'd0);
  assign ff[0] = ovr ? ovr_full : (fc[0] == 9'd256);
  assign ff[1] = (fc[1] == 9'd256);
  assign fu[0] = ovr ? ovr_usedw : fc[0][7:0];
  assign fu[1] = fc[1][7:0];
  assign wr_ok[0] = wr_en[0] && (fc[0] != 9'd256);
  assign wr_ok[1] = wr_en[1] && (fc[1] != 9'd256);
  assign rd_ok[0] = rdreq[0] && (fc[0] != 9'd0) && !ovr;
  assign rd_ok[1] = rdreq[1] && (fc[1] != 9'd0);

  always @(posedge clk or posedge frst) begin
    if (frst) begin
      for (int i = 0; i < 2; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
        fc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_ok[i]) begin
          mem[i][wp[i]] <= wr_data[i];
          wp[i] <= wp[i] + 8'd1;
        end
        if (rd_ok[i]) rp[i] <= rp[i] + 8'd1;
        fc[i] <= fc[i] + {8'd0, wr_ok[i]} - {8'd0, rd_ok[i]};
      end
    end
  end

  fifo_stream_reader #(.DWIDTH(16), .AWIDTH(8), .PKT_LEN(4)) u0 (
    .clk_i(clk), .arst_i(arst), .enable_i(en[0]),
    .fifo_q_i(fq[0]), .fifo_empty_i(fe[0]), .fifo_full_i(ff[0]),
    .fifo_usedw_i(fu[0]), .fifo_rdreq_o(rdreq[0]),
    .data_o(data[0]), .valid_o(valid[0]), .ready_i(rdy[0]),
    .sop_o(sop[0]), .eop_o(eop[0]), .busy_o(busy[0])
`ifdef FIFO_STREAM_READER_STATS_EN
    , .pkt_cnt_o(pkt_cnt[0])
`endif
  );

  fifo_stream_reader #(.DWIDTH(16), .AWIDTH(8), .PKT_LEN(1)) u1 (
    .clk_i(clk), .arst_i(arst), .enable_i(en[1]),
    .fifo_q_i(fq[1]), .fifo_empty_i(fe[1]), .fifo_full_i(ff[1]),
    .fifo_usedw_i(fu[1]), .fifo_rdreq_o(rdreq[1]),
    .data_o(data[1]), .valid_o(valid[1]), .ready_i(rdy[1]),
    .sop_o(sop[1]), .eop_o(eop[1]), .busy_o(busy[1])
`ifdef FIFO_STREAM_READER_STATS_EN
    , .pkt_cnt_o(pkt_cnt[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  int pos [2];
  int acc [2];
  int eops [2];
  int cyc = 0;
  int last_eop = 0;
  logic gap_en = 1'b0;
  logic have_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic wr(input int i, input logic [15:0] d);
    wr_en[i]   = 1'b1;
    wr_data[i] = d;
    if (i == 0) q0.push_back(d);
    else        q1.push_back(d);
    @(posedge clk); #1;
    wr_en[i] = 1'b0;
  endtask

  task automatic beat(input int i);
    logic [15:0] e;
    int pl;
    pl = (i == 0) ? 4 : 1;
    if (qsize(i) == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_beat: inst %0d data 0x%0h with nothing expected", i, data[i]);
      return;
    end
    if (i == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("data%0d", i), data[i], e);
    chk($sformatf("sop%0d", i), sop[i], pos[i] == 0);
    chk($sformatf("eop%0d", i), eop[i], pos[i] == pl - 1);
    pos[i] = (pos[i] == pl - 1) ? 0 : pos[i] + 1;
    acc[i]++;
    if (eop[i]) eops[i]++;
    if (i == 0 && gap_en) begin
      if (sop[i] && have_prev) chk("idle_gap", cyc - last_eop, 2);
      if (eop[i]) begin
        last_eop  = cyc;
        have_prev = 1'b1;
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (!gap_en) have_prev = 1'b0;
      for (int i = 0; i < 2; i++)
        if (!arst && valid[i] && rdy[i]) beat(i);
    end
  endtask

  task automatic wait_acc(input int i, input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (acc[i] >= target) return;
    end
    timeout("wait_acc");
  endtask

  task automatic wait_idle(input int i, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (!busy[i] && !valid[i]) return;
    end
    timeout("wait_idle");
  endtask

  task automatic wait_drain(input int i, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (qsize(i) == 0 && !busy[i] && !valid[i]) return;
    end
    timeout("wait_drain");
  endtask

  typedef struct {
    logic [7:0] usedw;
    logic       full;
    logic       en;
    logic       exp_busy;
  } vec_t;
  vec_t vt [8];

  int base;

  initial begin
    vt[0] = '{8'd0,   1'b0, 1'b1, 1'b0};
    vt[1] = '{8'd3,   1'b0, 1'b1, 1'b0};
    vt[2] = '{8'd4,   1'b0, 1'b1, 1'b1};
    vt[3] = '{8'd200, 1'b0, 1'b1, 1'b1};
    vt[4] = '{8'd255, 1'b0, 1'b0, 1'b0};
    vt[5] = '{8'd0,   1'b1, 1'b1, 1'b1};
    vt[6] = '{8'd0,   1'b1, 1'b0, 1'b0};
    vt[7] = '{8'd4,   1'b0, 1'b0, 1'b0};

    arst = 1'b1; frst = 1'b1; ovr = 1'b0; ovr_full = 1'b0; ovr_usedw = '0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; rdy[i] = 1'b1; wr_en[i] = 1'b0; wr_data[i] = '0;
      pos[i] = 0; acc[i] = 0; eops[i] = 0;
    end

    // reset state
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", valid[i], 0);
      chk("rst_sop",   sop[i],   0);
      chk("rst_eop",   eop[i],   0);
      chk("rst_busy",  busy[i],  0);
      chk("rst_data",  data[i],  0);
      chk("rst_rdreq", rdreq[i], 0);
    end
    @(posedge clk); #1;
    arst = 1'b0; frst = 1'b0;

    fork
      monitor();
    join_none

    // start decision table: overridden FIFO status, one edge, then reset
    ovr = 1'b1;
    for (int v = 0; v < 8; v++) begin
      ovr_usedw = vt[v].usedw;
      ovr_full  = vt[v].full;
      en[0]     = vt[v].en;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_busy", v), busy[0], vt[v].exp_busy);
      chk($sformatf("tbl%0d_rdreq", v), rdreq[0], vt[v].exp_busy);
      chk($sformatf("tbl%0d_valid", v), valid[0], 0);
      arst = 1'b1; #1; arst = 1'b0;
      en[0] = 1'b0;
    end
    ovr = 1'b0;
    @(posedge clk); #1;

    // partial packet waits, completion starts with exact latency
    en[0] = 1'b1;
    wr(0, 16'hA000); wr(0, 16'hA001); wr(0, 16'hA002);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("partial_busy", busy[0], 0);
      chk("partial_rdreq", rdreq[0], 0);
    end
    wr(0, 16'hA003);
    chk("lat_busy0", busy[0], 0);
    @(posedge clk); #1;
    chk("lat_busy1", busy[0], 1);
    chk("lat_rdreq1", rdreq[0], 1);
    chk("lat_valid1", valid[0], 0);
    @(posedge clk); #1;
    chk("lat_valid2", valid[0], 1);
    chk("lat_sop2", sop[0], 1);
    chk("lat_data2", data[0], 16'hA000);
    wait_drain(0, 50);
    chk("pktA_words", acc[0], 4);

    // full FIFO (usedw wraps to 0): 64 packets, one idle cycle apart
    en[0] = 1'b0;
    base = eops[0];
    for (int n = 0; n < 256; n++) wr(0, 16'h1000 + 16'(n));
    gap_en = 1'b1;
    en[0]  = 1'b1;
    @(posedge clk); #1;
    chk("full_start", busy[0], 1);
    wait_drain(0, 2000);
    chk("full_pkts", eops[0] - base, 64);
    gap_en = 1'b0;

    // downstream stall after word 2
    base = acc[0];
    wr(0, 16'hC000); wr(0, 16'hC001); wr(0, 16'hC002); wr(0, 16'hC003);
    wait_acc(0, base + 2, 40);
    rdy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", valid[0], 1);
      chk("stall_data", data[0], 16'hC002);
      chk("stall_sop", sop[0], 0);
      chk("stall_eop", eop[0], 0);
      chk("stall_rdreq", rdreq[0], 0);
    end
    @(posedge clk); #1;
    rdy[0] = 1'b1;
    wait_drain(0, 50);
    chk("stall_words", acc[0] - base, 4);

    // enable dropped mid-packet: packet completes, nothing new starts
    en[0] = 1'b0;
    base = acc[0];
    for (int n = 0; n < 12; n++) wr(0, 16'hD000 + 16'(n));
    en[0] = 1'b1;
    wait_acc(0, base + 1, 40);
    en[0] = 1'b0;
    wait_idle(0, 40);
    repeat (8) @(posedge clk);
    #1;
    chk("endrop_busy", busy[0], 0);
    chk("endrop_rdreq", rdreq[0], 0);
    chk("endrop_words", acc[0] - base, 4);
    en[0] = 1'b1;
    wait_drain(0, 100);
    chk("endrop_all", acc[0] - base, 12);

    // reset mid-packet: third popped word is lost, next packet starts clean
    base = acc[0];
    wr(0, 16'hE000); wr(0, 16'hE001); wr(0, 16'hE002); wr(0, 16'hE003);
    wait_acc(0, base + 2, 40);
    arst = 1'b1;
    #1;
    chk("arst_valid", valid[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_sop", sop[0], 0);
    chk("arst_eop", eop[0], 0);
    chk("arst_rdreq", rdreq[0], 0);
    void'(q0.pop_front());
    pos[0]  = 0;
    eops[0] = 0;
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk); #1;
    wr(0, 16'hE004); wr(0, 16'hE005); wr(0, 16'hE006);
    wait_drain(0, 50);
    chk("arst_words", acc[0] - base, 6);

    // PKT_LEN=1: five single-word packets
    en[1] = 1'b1;
    for (int n = 0; n < 5; n++) wr(1, 16'h5000 + 16'(n));
    wait_drain(1, 50);
    chk("len1_pkts", eops[1], 5);
    chk("len1_words", acc[1], 5);

`ifdef FIFO_STREAM_READER_STATS_EN
    chk("stats_len1", pkt_cnt[1], 5);
    chk("stats_len4", pkt_cnt[0], eops[0]);
`endif

    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
